dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_arbiter.sv | 87 ++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus bundle: pipeline port, loader port, SRAM port and stall counter.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              cpuReq;
    logic              cpuWrite;
    logic [ADDR_W-1:0] cpuAdrx;
    logic [DATA_W-1:0] cpuDataIn;
    logic              cpuGrant;
    logic              cpuRdValid;
    logic [DATA_W-1:0] cpuRdData;

    logic              ldReq;
    logic              ldWrite;
    logic [ADDR_W-1:0] ldAdrx;
    logic [DATA_W-1:0] ldDataIn;
    logic              ldGrant;
    logic              ldRdValid;
    logic [DATA_W-1:0] ldRdData;

    logic [ADDR_W-1:0] memAdrx;
    logic [DATA_W-1:0] memDataIn;
    logic              memWrite;
    logic [DATA_W-1:0] memDataOut;

    logic [15:0]       stallCount;

    modport slave (
        input  cpuReq, cpuWrite, cpuAdrx, cpuDataIn,
        output cpuGrant, cpuRdValid, cpuRdData,
        input  ldReq, ldWrite, ldAdrx, ldDataIn,
        output ldGrant, ldRdValid, ldRdData,
        output memAdrx, memDataIn, memWrite,
        input  memDataOut,
        output stallCount
    );

    modport master (
        output cpuReq, cpuWrite, cpuAdrx, cpuDataIn,
        input  cpuGrant, cpuRdValid, cpuRdData,
        output ldReq, ldWrite, ldAdrx, ldDataIn,
        input  ldGrant, ldRdValid, ldRdData,
        input  memAdrx, memDataIn, memWrite,
        output memDataOut,
        input  stallCount
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU pipeline has priority, the loader wins after
// STARVE_MAX consecutive lost cycles. Read results return one cycle after the grant.
module dmem_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [SW-1:0]     starve_q, starve_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic              rd_vld_q, rd_vld_d;
    logic              rd_own_ld_q, rd_own_ld_d;
    logic [ADDR_W-1:0] mem_adrx_q, mem_adrx_d;

    logic              ld_win, cpu_win, any_win, win_write, rd_vld;
    logic [ADDR_W-1:0] win_adrx;

    function automatic logic [SW-1:0] starve_inc(input logic [SW-1:0] v);
        return (v == STARVE_LIM) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] stall_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Grants are suppressed outright while reset is high.
    always_comb begin
        ld_win    = !reset && bus.ldReq && (!bus.cpuReq || starve_q == STARVE_LIM);
        cpu_win   = !reset && bus.cpuReq && !ld_win;
        any_win   = ld_win || cpu_win;
        win_adrx  = ld_win ? bus.ldAdrx : bus.cpuAdrx;
        win_write = ld_win ? bus.ldWrite : (cpu_win && bus.cpuWrite);
    end

    // A reset in the cycle after a granted read kills that read's result.
    assign rd_vld         = rd_vld_q && !reset;
    assign bus.cpuGrant   = cpu_win;
    assign bus.ldGrant    = ld_win;
    assign bus.memAdrx    = any_win ? win_adrx : mem_adrx_q;
    assign bus.memDataIn  = ld_win ? bus.ldDataIn : bus.cpuDataIn;
    assign bus.memWrite   = win_write;
    assign bus.cpuRdValid = rd_vld && !rd_own_ld_q;
    assign bus.ldRdValid  = rd_vld && rd_own_ld_q;
    assign bus.cpuRdData  = bus.cpuRdValid ? bus.memDataOut : '0;
    assign bus.ldRdData   = bus.ldRdValid ? bus.memDataOut : '0;
    assign bus.stallCount = stall_cnt_q;

    always_comb begin
        starve_d    = starve_q;
        stall_cnt_d = stall_cnt_q;
        rd_vld_d    = any_win && !win_write;
        rd_own_ld_d = ld_win;
        mem_adrx_d  = any_win ? win_adrx : mem_adrx_q;

        if (!bus.ldReq || ld_win) begin
            starve_d = '0;
        end else if (cpu_win) begin
            starve_d = starve_inc(starve_q);
        end

        if (bus.cpuReq && !cpu_win) begin
            stall_cnt_d = stall_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q    <= '0;
            stall_cnt_q <= '0;
            rd_vld_q    <= 1'b0;
            rd_own_ld_q <= 1'b0;
            mem_adrx_q  <= '0;
        end else begin
            starve_q    <= starve_d;
            stall_cnt_q <= stall_cnt_d;
            rd_vld_q    <= rd_vld_d;
            rd_own_ld_q <= rd_own_ld_d;
            mem_adrx_q  <= mem_adrx_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus random traffic against a
// cycle-level reference of the arbitration rules and a behavioural SRAM.
module tb_dmem_arbiter;
    localparam int ADDR_W     = 11;
    localparam int DATA_W     = 16;
    localparam int STARVE_MAX = 4;
    localparam int DEPTH      = 1 << ADDR_W;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifc ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (ifc)
    );

    // Behavioural registered-read SRAM.
    logic [DATA_W-1:0] sram [DEPTH];
    always @(posedge clk) begin
        if (ifc.memWrite) sram[ifc.memAdrx] <= ifc.memDataIn;
        ifc.memDataOut <= sram[ifc.memAdrx];
    end

    // Reference state.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    int                m_starve, m_stall;
    bit                m_pend, m_own_ld;
    logic [DATA_W-1:0] m_rd_data;
    logic [ADDR_W-1:0] m_last_adr;

    int n_checks = 0;
    int n_errors = 0;

    // Last sampled DUT outputs, for scenario-level checks.
    logic              obs_cg, obs_lg, obs_crv, obs_lrv;
    logic [DATA_W-1:0] obs_crd, obs_lrd;
    logic [15:0]       obs_stall;

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return DATA_W'((i * 311) ^ 23040);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input bit r, input bit cr, input bit cw, input int ca, input int cd,
                         input bit lr, input bit lw, input int la, input int ld);
        reset         = r;
        ifc.cpuReq    = cr;
        ifc.cpuWrite  = cw;
        ifc.cpuAdrx   = ADDR_W'(ca);
        ifc.cpuDataIn = DATA_W'(cd);
        ifc.ldReq     = lr;
        ifc.ldWrite   = lw;
        ifc.ldAdrx    = ADDR_W'(la);
        ifc.ldDataIn  = DATA_W'(ld);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Called just after a falling edge with inputs applied: check, then advance one cycle.
    task automatic step();
        bit                r, ld_w, cpu_w, any_w, wr_w, exp_cv, exp_lv;
        logic [ADDR_W-1:0] w_adr, exp_adr;
        logic [DATA_W-1:0] w_din;
        #2;
        r      = reset;
        ld_w   = !r && ifc.ldReq && (!ifc.cpuReq || m_starve == STARVE_MAX);
        cpu_w  = !r && ifc.cpuReq && !ld_w;
        any_w  = ld_w || cpu_w;
        w_adr  = ld_w ? ifc.ldAdrx : ifc.cpuAdrx;
        w_din  = ld_w ? ifc.ldDataIn : ifc.cpuDataIn;
        wr_w   = ld_w ? ifc.ldWrite : (cpu_w && ifc.cpuWrite);
        exp_adr = any_w ? w_adr : m_last_adr;
        exp_cv = !r && m_pend && !m_own_ld;
        exp_lv = !r && m_pend && m_own_ld;

        obs_cg = ifc.cpuGrant;  obs_lg = ifc.ldGrant;
        obs_crv = ifc.cpuRdValid; obs_lrv = ifc.ldRdValid;
        obs_crd = ifc.cpuRdData;  obs_lrd = ifc.ldRdData;
        obs_stall = ifc.stallCount;

        check_val("cpuGrant", 32'(ifc.cpuGrant), 32'(cpu_w));
        check_val("ldGrant", 32'(ifc.ldGrant), 32'(ld_w));
        check_val("memWrite", 32'(ifc.memWrite), 32'(wr_w));
        check_val("memAdrx", 32'(ifc.memAdrx), 32'(exp_adr));
        if (wr_w) check_val("memDataIn", 32'(ifc.memDataIn), 32'(w_din));
        check_val("cpuRdValid", 32'(ifc.cpuRdValid), 32'(exp_cv));
        check_val("ldRdValid", 32'(ifc.ldRdValid), 32'(exp_lv));
        check_val("cpuRdData", 32'(ifc.cpuRdData), exp_cv ? 32'(m_rd_data) : 32'd0);
        check_val("ldRdData", 32'(ifc.ldRdData), exp_lv ? 32'(m_rd_data) : 32'd0);
        check_val("stallCount", 32'(ifc.stallCount), 32'(m_stall));

        @(posedge clk);
        if (r) begin
            m_starve = 0; m_stall = 0; m_pend = 0; m_own_ld = 0; m_last_adr = '0;
        end else begin
            if (ifc.cpuReq && !cpu_w && m_stall < 32'hFFFF) m_stall++;
            if (!ifc.ldReq || ld_w) m_starve = 0;
            else if (cpu_w && m_starve < STARVE_MAX) m_starve++;
            m_pend   = any_w && !wr_w;
            m_own_ld = ld_w;
            if (m_pend) m_rd_data = ref_mem[w_adr];
            if (wr_w) ref_mem[w_adr] = w_din;
            if (any_w) m_last_adr = w_adr;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1, 1, 1, 3, 9, 1, 1, 4, 7);
        step();
        check_val("reset_grants", 32'({obs_cg, obs_lg}), 32'd0);
        idle();
        step();
        check_val("post_reset_rdvalid", 32'({obs_crv, obs_lrv}), 32'd0);
        check_val("post_reset_stall", 32'(obs_stall), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            sram[i]    = init_word(i);
            ref_mem[i] = init_word(i);
        end
        m_starve = 0; m_stall = 0; m_pend = 0; m_own_ld = 0;
        m_rd_data = '0; m_last_adr = '0;

        // Uncheckeded first reset edge brings the DUT out of its power-up state.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        do_reset();

        // Loader write then read back of the same word.
        drive(0, 0, 0, 0, 0, 1, 1, 5, 16'h1234);
        step();
        check_val("ld_wr_grant", 32'(obs_lg), 32'd1);
        drive(0, 0, 0, 0, 0, 1, 0, 5, 0);
        step();
        check_val("ld_rd_grant", 32'(obs_lg), 32'd1);
        check_val("ld_wr_no_rdvalid", 32'({obs_crv, obs_lrv}), 32'd0);
        idle();
        step();
        check_val("ld_rd_valid", 32'(obs_lrv), 32'd1);
        check_val("ld_rd_data", 32'(obs_lrd), 32'h1234);
        check_val("ld_rd_cpu_quiet", 32'(obs_crv), 32'd0);

        // Contention: C,C,C,C,L repeating.
        for (int i = 0; i < 10; i++) begin
            drive(0, 1, 0, 8, 0, 1, 0, 9, 0);
            step();
            check_val("contend_ld", 32'(obs_lg), 32'((i % 5) == 4));
            check_val("contend_cpu", 32'(obs_cg), 32'((i % 5) != 4));
        end
        idle();
        step();
        check_val("contend_stall", 32'(obs_stall), 32'd2);

        // CPU read then loader read back to back.
        drive(0, 1, 0, 16'h010, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 16'h011, 0);
        step();
        check_val("b2b_cpu_valid", 32'(obs_crv), 32'd1);
        check_val("b2b_cpu_data", 32'(obs_crd), 32'(init_word(16'h010)));
        check_val("b2b_ld_quiet", 32'(obs_lrv), 32'd0);
        idle();
        step();
        check_val("b2b_ld_valid", 32'(obs_lrv), 32'd1);
        check_val("b2b_ld_data", 32'(obs_lrd), 32'(init_word(16'h011)));
        check_val("b2b_cpu_quiet", 32'(obs_crv), 32'd0);

        // CPU alone for 20 cycles never stalls.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, i[0], i, i * 7, 0, 0, 0, 0);
            step();
            check_val("cpu_only_grant", 32'({obs_cg, obs_lg}), 32'b10);
            check_val("cpu_only_stall", 32'(obs_stall), 32'd0);
        end

        // Seven stalls, a granted CPU read, then reset in the following cycle.
        do_reset();
        for (int i = 0; i < 35; i++) begin
            drive(0, 1, 0, 20, 0, 1, 0, 21, 0);
            step();
        end
        drive(0, 1, 0, 16'h022, 0, 0, 0, 0, 0);
        step();
        check_val("pre_reset_grant", 32'(obs_cg), 32'd1);
        check_val("pre_reset_stall", 32'(obs_stall), 32'd7);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_val("reset_kills_rdvalid", 32'(obs_crv), 32'd0);
        idle();
        step();
        check_val("after_reset_rdvalid", 32'(obs_crv), 32'd0);
        check_val("after_reset_stall", 32'(obs_stall), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(0, 1, 0, 30, 0, 1, 0, 31, 0);
            step();
            check_val("after_reset_starve", 32'(obs_lg), 32'(i == 4));
        end

        // Saturation of the stall counter.
        do_reset();
        force dut.stall_cnt_q = 16'hFFFE;
        #1;
        release dut.stall_cnt_q;
        m_stall = 32'hFFFE;
        for (int i = 0; i < 15; i++) begin
            drive(0, 1, 0, 40, 0, 1, 0, 41, 0);
            step();
        end
        idle();
        step();
        check_val("stall_saturate", 32'(obs_stall), 32'hFFFF);
        idle();
        step();
        check_val("stall_hold", 32'(obs_stall), 32'hFFFF);

        // Random traffic on a small address window.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15), $urandom_range(0, 16'hFFFF),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 15), $urandom_range(0, 16'hFFFF));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
